// File: rtl/pipe_sel_mux.sv
// N-way WIDTH-bit selector with a registered output (M) and a 1-word skid register (S).
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 beat/cycle.
// Backpressure: in_ready = occupancy < 2, from registered state only. Macro PIPE_SEL_MUX_ZERO_IDLE_EN zeroes out_data while idle.
module pipe_sel_mux #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr,
  output logic [1:0]              occupancy
);

  logic             m_vld;
  logic [WIDTH-1:0] m_dat;
  logic             s_vld;
  logic [WIDTH-1:0] s_dat;
  logic [WIDTH-1:0] sel_word;
  logic             sel_oor;
  logic             accept;
  logic             drain;

  // Pick the addressed input word; any select with no matching input is out of range.
  always_comb begin
    sel_word = DEFAULT_VAL;
    sel_oor  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
        sel_oor  = 1'b0;
      end
    end
  end

  // S can only be full when M is full, so occupancy is just the sum of the two valids.
  assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};
  assign in_ready  = (occupancy != 2'd2);
  assign accept    = in_valid & in_ready;
  assign drain     = m_vld & out_ready;
  assign out_valid = m_vld;

`ifdef PIPE_SEL_MUX_ZERO_IDLE_EN
  assign out_data = m_vld ? m_dat : '0;
`else
  assign out_data = m_dat;
`endif

  // Two-entry storage: M feeds the output, S absorbs the beat accepted while M is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_vld <= 1'b0;
      m_dat <= '0;
      s_vld <= 1'b0;
      s_dat <= '0;
    end else if (flush) begin
      // Flush discards held beats and any beat offered this cycle; M data is left as-is.
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (drain) begin
      if (s_vld) begin
        m_dat <= s_dat;
        m_vld <= 1'b1;
        s_vld <= accept;
        if (accept) s_dat <= sel_word;
      end else begin
        m_vld <= accept;
        if (accept) m_dat <= sel_word;
      end
    end else if (accept) begin
      if (!m_vld) begin
        m_dat <= sel_word;
        m_vld <= 1'b1;
      end else begin
        s_dat <= sel_word;
        s_vld <= 1'b1;
      end
    end
  end

  // Sticky out-of-range flag; a new error wins over a clear, and flush does not mask it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Scoreboard bench for pipe_sel_mux with a 3-input, 32-bit configuration.
// Driver pushes the expected word of every accepted beat; a negedge monitor pops on each drain.
// The held-beat queue doubles as the occupancy/ready/valid reference.
module tb_pipe_sel_mux;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
  localparam logic [WIDTH-1:0] DEF = 32'hDEAD_BEEF;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic                    err_clr;
  logic [1:0]              occupancy;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic err_mdl = 1'b0;
  logic [NUM_IN*WIDTH-1:0] fixed_d;

  pipe_sel_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEFAULT_VAL(DEF)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .err_clr(err_clr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT's visible state against the held-beat queue and the error model.
  task automatic check_state();
    chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("sel_err", 32'(sel_err), 32'(err_mdl));
`ifdef PIPE_SEL_MUX_ZERO_IDLE_EN
    if (exp_q.size() == 0) chk("idle_zero", out_data, 32'h0);
`endif
  endtask

  // Apply one cycle of stimulus, update the reference for the coming edge, then check after it.
  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic fl,
                       input logic ec, input logic ordy, input logic [NUM_IN*WIDTH-1:0] d);
    logic acc;
    logic [WIDTH-1:0] w;
    in_valid = v; sel = s; flush = fl; err_clr = ec; out_ready = ordy; in_data = d;
    acc = v && (exp_q.size() < 2);
    w = DEF;
    for (int i = 0; i < NUM_IN; i++) if (int'(s) == i) w = d[i*WIDTH +: WIDTH];
    if (acc && int'(s) >= NUM_IN) err_mdl = 1'b1;
    else if (ec) err_mdl = 1'b0;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(w);
    @(posedge clk); #1;
    check_state();
  endtask

  // Monitor: a drain happens at the next edge when out_valid & out_ready and no flush.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'h0);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; sel = '0; flush = 1'b0; err_clr = 1'b0;
    out_ready = 1'b0; in_data = '0;
    fixed_d = {32'h33, 32'h22, 32'h11};
    #22 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Single beat, sel=2 -> 0x33 one cycle later, then empty.
    drive(1, 2'd2, 0, 0, 1, fixed_d);
    chk("t1_data", out_data, 32'h33);
    drive(0, 2'd0, 0, 0, 1, fixed_d);

    // Back-pressure: third offer refused, then drained in order and re-offered.
    drive(1, 2'd0, 0, 0, 0, fixed_d);
    drive(1, 2'd1, 0, 0, 0, fixed_d);
    chk("t2_full", 32'(in_ready), 32'h0);
    drive(1, 2'd2, 0, 0, 0, fixed_d);
    drive(0, 2'd2, 0, 0, 1, fixed_d);
    drive(1, 2'd2, 0, 0, 1, fixed_d);
    repeat (3) drive(0, 2'd0, 0, 0, 1, fixed_d);

    // Full throughput with sel cycling 0..3 (3 is out of range -> DEF, sets sel_err).
    for (int i = 0; i < 8; i++)
      drive(1, SEL_W'(i % 4), 0, 0, 1, {$urandom, $urandom, $urandom});
    drive(0, 2'd0, 0, 0, 1, fixed_d);

    // Error flag: clear without a new error, then clear racing a new error.
    drive(0, 2'd0, 0, 1, 1, fixed_d);
    chk("t4_cleared", 32'(sel_err), 32'h0);
    drive(1, 2'd3, 0, 0, 1, fixed_d);
    chk("t4_def", out_data, DEF);
    drive(1, 2'd3, 0, 1, 1, fixed_d);
    chk("t4_set_wins", 32'(sel_err), 32'h1);
    drive(0, 2'd0, 0, 1, 1, fixed_d);

    // Flush with two held beats and a beat on offer.
    drive(1, 2'd0, 0, 0, 0, fixed_d);
    drive(1, 2'd1, 0, 0, 0, fixed_d);
    drive(1, 2'd2, 1, 0, 1, fixed_d);
    chk("t5_flushed", 32'(out_valid), 32'h0);
    repeat (2) drive(0, 2'd0, 0, 0, 1, fixed_d);

    // Asynchronous reset between edges with two beats held.
    drive(1, 2'd0, 0, 0, 0, fixed_d);
    drive(1, 2'd3, 0, 0, 0, fixed_d);
    in_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'h0);
    chk("t6_occupancy", 32'(occupancy), 32'h0);
    chk("t6_out_data", out_data, 32'h0);
    chk("t6_sel_err", 32'(sel_err), 32'h0);
    exp_q.delete();
    err_mdl = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
    #1 chk("t6_in_ready", 32'(in_ready), 32'h1);
    drive(1, 2'd1, 0, 0, 1, fixed_d);
    chk("t6_latency", out_data, 32'h22);
    drive(0, 2'd0, 0, 0, 1, fixed_d);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 3) != 0, SEL_W'($urandom_range(0, 3)), $urandom_range(0, 31) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom});
    repeat (4) drive(0, 2'd0, 0, 0, 1, fixed_d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_sel_mux.md
Name: pipe_sel_mux

Overview:
Parametrised N-way, WIDTH-bit selector with a registered output stage and a 2-entry skid buffer, so one word can be accepted every cycle under back-pressure.
- Successor to the fixed 2:1 datapath muxes in the pipelined CPU.
- Sits between pipeline stages, e.g. the forwarding select feeding the EX operand register.
- Adds a valid/ready handshake, flush, out-of-range select detection and an occupancy count.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 4, number of selectable inputs (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
DEFAULT_VAL, 32'h0000_0000, value substituted when sel >= NUM_IN

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_data  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH]
sel  in  SEL_W  select for the current beat
in_valid  in  1  upstream beat valid
in_ready  out  1  block can accept a beat this cycle
flush  in  1  synchronous discard of all held beats
out_data  out  WIDTH  selected data
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
sel_err  out  1  sticky out-of-range-select flag
err_clr  in  1  synchronous clear of sel_err
occupancy  out  2  held beats (0..2)

Behaviour:
Interface:
- Single clock clk.
- reset_n is asynchronous, active-low.

Reset values:
- out_valid=0, out_data=0, sel_err=0, occupancy=0.
- in_ready=1 after reset deassertion.

Selection:
- Value = in_data[sel*WIDTH +: WIDTH] if sel < NUM_IN, else DEFAULT_VAL.
- Evaluated at accept time; the chosen word is stored, not the select.

Handshake:
- Accept = in_valid & in_ready.
- Drain = out_valid & out_ready.
- in_ready = (occupancy < 2), computed from registered state only; no combinational path from out_ready.

Storage:
- Main register M drives out_data/out_valid. Skid register S.
- Accept with M empty, or M draining with S empty: word goes to M.
- Accept while M full and not draining: word goes to S.
- Drain with S full: S moves to M the same edge; any simultaneous accept goes to S.
- Latency: 1 cycle from accept to out_valid when empty.
- Throughput: 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO; no beat is dropped or duplicated.

Occupancy:
- occupancy_next = occupancy + accept - drain.
- Never exceeds 2; never underflows.

Flush:
- Clears M and S (out_valid=0, occupancy=0) at the next edge.
- Has priority over accept and drain; a beat offered in the flush cycle is discarded.
- in_ready is unaffected by flush.

Error flag:
- sel_err sets on any accept with sel >= NUM_IN, including while flush is asserted.
- err_clr clears it; set wins over a simultaneous clear.

Reset mid-operation:
- All state is cleared immediately (asynchronously).
- Held beats are lost; no output glitch after release.

out_data when empty:
- Retains the last drained value, or 0 after reset. See the optional feature.

Optional Feature:
Macro: PIPE_SEL_MUX_ZERO_IDLE_EN
- Defined: out_data is forced to 0 whenever out_valid=0, including after flush and final drain. Aids waveform debug and power.
- Undefined: out_data holds the last M contents while idle. No extra gating logic.

Test Plan:
1. Reset then single beat: NUM_IN=4, in_data words {0x44,0x33,0x22,0x11} (input 0 = 0x11), sel=2, in_valid one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x33, occupancy=1, then 0.
2. Back-pressure: out_ready=0, offer beats with sel=0,1,2 on consecutive cycles -> in_ready drops after the 2nd accept, occupancy=2. Raise out_ready -> outputs are 0x11, 0x22, then the 3rd beat once re-offered, in order.
3. Full throughput: out_ready=1, 8 beats back-to-back with sel cycling 0..3 -> 8 outputs in order, one per cycle, in_ready never drops.
4. Out-of-range: NUM_IN=3, sel=3 accepted -> out_data=DEFAULT_VAL, sel_err=1 and stays 1. err_clr with no new error -> 0. err_clr together with another sel=3 accept -> stays 1.
5. Flush: occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, the offered beat never appears.
6. Async reset mid-stream: drop reset_n between clock edges with occupancy=2 -> outputs go to reset values immediately. After release, the first new beat appears with 1-cycle latency.
